// File: rtl/array_access_sched_if.sv
// Request/grant, clear and response signals shared by requesters A/B and the array scheduler.
// "master" is the requester side, "slave" the scheduler side.
interface array_access_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic              a_req;
  logic [1:0]        a_op;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;

  logic              b_req;
  logic [1:0]        b_op;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;

  logic              clr_req;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output a_req, a_op, a_addr, a_wdata,
    output b_req, b_op, b_addr, b_wdata,
    output clr_req,
    input  a_gnt, b_gnt,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  a_req, a_op, a_addr, a_wdata,
    input  b_req, b_op, b_addr, b_wdata,
    input  clr_req,
    output a_gnt, b_gnt,
    output rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/array_access_sched.sv
// Owns the 4 x 32-bit working array: round-robin arbitration between A and B, two-cycle
// read-modify-write for HALVE/SHR2, and a prioritised 4-cycle sweep clear.
module array_access_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  array_access_sched_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_HALVE = 2'b01;
  localparam logic [1:0] OP_SHR2  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RMW   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              clr_pend_r;
  logic              clr_pend_s;
  logic              rr_last_r;   // 0 = A granted last, 1 = B granted last
  logic              rr_last_s;
  logic [ADDR_W-1:0] sweep_ptr_r;
  logic [ADDR_W-1:0] sweep_ptr_s;

  logic              rmw_id_r;
  logic [1:0]        rmw_op_r;
  logic [ADDR_W-1:0] rmw_addr_r;
  logic [DATA_W-1:0] rmw_new_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  logic              a_gnt_s;
  logic              b_gnt_s;
  logic              grant_s;
  logic              sel_id_s;
  logic [1:0]        sel_op_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              rsp_valid_r;
  logic              rsp_valid_s;
  logic              rsp_id_r;
  logic              rsp_id_s;
  logic [DATA_W-1:0] rsp_data_r;
  logic [DATA_W-1:0] rsp_data_s;

  // Logical right shift with zero fill for the two read-modify-write operations.
  function automatic logic [DATA_W-1:0] rmw_result(input logic [1:0] op,
                                                   input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] res;
    case (op)
      OP_HALVE: res = value >> 2'd1;
      OP_SHR2:  res = value >> 2'd2;
      default:  res = value;
    endcase
    return res;
  endfunction

  // Round-robin arbitration; only an IDLE cycle without a pending clear may grant.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if ((state_r == ST_IDLE) && !clr_pend_r) begin
      if (bus.a_req && bus.b_req) begin
        if (rr_last_r) begin
          a_gnt_s = 1'b1;
        end else begin
          b_gnt_s = 1'b1;
        end
      end else begin
        a_gnt_s = bus.a_req;
        b_gnt_s = bus.b_req;
      end
    end else begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end
  end

  // Route the winning requester's operation to the datapath.
  always_comb begin
    grant_s  = a_gnt_s | b_gnt_s;
    sel_id_s = b_gnt_s;
    if (b_gnt_s) begin
      sel_op_s    = bus.b_op;
      sel_addr_s  = bus.b_addr;
      sel_wdata_s = bus.b_wdata;
    end else begin
      sel_op_s    = bus.a_op;
      sel_addr_s  = bus.a_addr;
      sel_wdata_s = bus.a_wdata;
    end
  end

  // FSM next state, array write port and response generation.
  always_comb begin
    state_s     = state_r;
    clr_pend_s  = clr_pend_r | (bus.clr_req && (state_r != ST_SWEEP));
    rr_last_s   = rr_last_r;
    sweep_ptr_s = sweep_ptr_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = sel_addr_s;
    mem_wdata_s = sel_wdata_s;
    rsp_valid_s = 1'b0;
    rsp_id_s    = rsp_id_r;
    rsp_data_s  = rsp_data_r;
    rmw_new_s   = rmw_result(rmw_op_r, mem_r[rmw_addr_r]);
    case (state_r)
      ST_IDLE: begin
        if (clr_pend_r) begin
          // A clear arriving in this very cycle merges with the sweep being started.
          state_s     = ST_SWEEP;
          clr_pend_s  = 1'b0;
          sweep_ptr_s = '0;
        end else if (grant_s) begin
          rr_last_s = sel_id_s;
          rsp_id_s  = sel_id_s;
          case (sel_op_s)
            OP_WRITE: begin
              mem_we_s    = 1'b1;
              rsp_valid_s = 1'b1;
              rsp_data_s  = sel_wdata_s;
            end
            OP_READ: begin
              rsp_valid_s = 1'b1;
              rsp_data_s  = mem_r[sel_addr_s];
            end
            default: begin
              state_s = ST_RMW;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RMW: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = rmw_addr_r;
        mem_wdata_s = rmw_new_s;
        rsp_valid_s = 1'b1;
        rsp_id_s    = rmw_id_r;
        rsp_data_s  = rmw_new_s;
        state_s     = ST_IDLE;
      end
      ST_SWEEP: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = sweep_ptr_r;
        mem_wdata_s = '0;
        sweep_ptr_s = sweep_ptr_r + ADDR_W'(1);
        if (sweep_ptr_r == {ADDR_W{1'b1}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SWEEP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state, captured RMW operation and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      clr_pend_r  <= 1'b0;
      rr_last_r   <= 1'b1;
      sweep_ptr_r <= '0;
      rmw_id_r    <= 1'b0;
      rmw_op_r    <= 2'b00;
      rmw_addr_r  <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      clr_pend_r  <= clr_pend_s;
      rr_last_r   <= rr_last_s;
      sweep_ptr_r <= sweep_ptr_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_id_r    <= rsp_id_s;
      rsp_data_r  <= rsp_data_s;
      if (grant_s) begin
        rmw_id_r   <= sel_id_s;
        rmw_op_r   <= sel_op_s;
        rmw_addr_r <= sel_addr_s;
      end
    end
  end

  // Array storage; reset zeroes every entry so an aborted RMW or sweep leaves a clean array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.a_gnt     = a_gnt_s;
  assign bus.b_gnt     = b_gnt_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = (state_r != ST_IDLE) || clr_pend_r;

endmodule

// File: tb/tb_array_access_sched.sv
// Self-checking bench for array_access_sched: directed vector table, hand-written
// multi-cycle corner sequences, then random traffic against a transaction-level model.
module tb_array_access_sched;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam logic [1:0] OPW = 2'b00;
  localparam logic [1:0] OPH = 2'b01;
  localparam logic [1:0] OPS = 2'b10;
  localparam logic [1:0] OPR = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  array_access_sched_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  array_access_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        ar;  logic [1:0] aop; logic [1:0] aad; logic [31:0] awd;
    logic        br;  logic [1:0] bop; logic [1:0] bad; logic [31:0] bwd;
    logic        ag;  logic       bg;  logic       rv;  logic        rid;
    logic [31:0] rd;  logic       bsy;
  } vec_t;
  vec_t tbl [11];

  typedef struct { int due; logic id; logic [31:0] d; } rsp_t;
  rsp_t q [$];

  // Reference model state: array contents, last winner, first free cycle, pending clear.
  logic [31:0] mm [4];
  logic        m_last;
  logic        m_pend;
  int          m_free;
  int          m_win;
  int          c;

  logic        ap, bp, clr, ea, eb, wid, ebusy;
  logic [1:0]  aop_v, bop_v, aad_v, bad_v, op_v, ad_v;
  logic [31:0] awd_v, bwd_v, wd_v, rd_v;
  rsp_t        r;

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_a(input logic req, input logic [1:0] op, input logic [1:0] ad,
                       input logic [31:0] wd);
    bus.a_req = req; bus.a_op = op; bus.a_addr = ad; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic [1:0] op, input logic [1:0] ad,
                       input logic [31:0] wd);
    bus.b_req = req; bus.b_op = op; bus.b_addr = ad; bus.b_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_a(1'b0, OPW, 2'd0, 32'h0);
    set_b(1'b0, OPW, 2'd0, 32'h0);
    bus.clr_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  // A single A write: grant now, echo of the written data one cycle later.
  task automatic do_write_a(input logic [1:0] ad, input logic [31:0] wd);
    set_a(1'b1, OPW, ad, wd);
    @(negedge clk);
    chk1("wr_gnt", bus.a_gnt, 1'b1);
    step();
    set_a(1'b0, OPW, 2'd0, 32'h0);
    @(negedge clk);
    chk1("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk32("wr_rsp_data", bus.rsp_data, wd);
    step();
  endtask

  task automatic do_read_a(input logic [1:0] ad, input logic [31:0] exp);
    set_a(1'b1, OPR, ad, 32'h0);
    @(negedge clk);
    chk1("rd_gnt", bus.a_gnt, 1'b1);
    step();
    set_a(1'b0, OPW, 2'd0, 32'h0);
    @(negedge clk);
    chk1("rd_rsp_valid", bus.rsp_valid, 1'b1);
    chk32("rd_rsp_data", bus.rsp_data, exp);
    step();
  endtask

  initial begin
    bus.clr_req = 1'b0;
    set_a(1'b0, OPW, 2'd0, 32'h0);
    set_b(1'b0, OPW, 2'd0, 32'h0);
    reset = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("reset_rsp_id", bus.rsp_id, 1'b0);
    chk32("reset_rsp_data", bus.rsp_data, 32'h0);
    chk1("reset_busy", bus.busy, 1'b0);
    reset = 1'b0;
    step();

    // ---------------- directed table ----------------
    tbl[0]  = '{1'b1, OPW, 2'd0, 32'h10, 1'b1, OPW, 2'd1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b0, OPW, 2'd0, 32'h0,  1'b1, OPW, 2'd1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0};
    tbl[2]  = '{1'b1, OPR, 2'd0, 32'h0,  1'b0, OPW, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0};
    tbl[3]  = '{1'b0, OPW, 2'd0, 32'h0,  1'b1, OPR, 2'd1, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0};
    tbl[4]  = '{1'b1, OPW, 2'd2, 32'h7,  1'b0, OPW, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0};
    tbl[5]  = '{1'b1, OPH, 2'd2, 32'h0,  1'b0, OPW, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h7,  1'b0};
    tbl[6]  = '{1'b1, OPS, 2'd2, 32'h0,  1'b1, OPR, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
    tbl[7]  = '{1'b1, OPS, 2'd2, 32'h0,  1'b1, OPR, 2'd0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h3,  1'b0};
    tbl[8]  = '{1'b1, OPS, 2'd2, 32'h0,  1'b0, OPW, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0};
    tbl[9]  = '{1'b0, OPW, 2'd0, 32'h0,  1'b0, OPW, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
    tbl[10] = '{1'b0, OPW, 2'd0, 32'h0,  1'b0, OPW, 2'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    for (int i = 0; i < 11; i++) begin
      set_a(tbl[i].ar, tbl[i].aop, tbl[i].aad, tbl[i].awd);
      set_b(tbl[i].br, tbl[i].bop, tbl[i].bad, tbl[i].bwd);
      @(negedge clk);
      chk1($sformatf("tbl%0d_a_gnt", i), bus.a_gnt, tbl[i].ag);
      chk1($sformatf("tbl%0d_b_gnt", i), bus.b_gnt, tbl[i].bg);
      chk1($sformatf("tbl%0d_rsp_valid", i), bus.rsp_valid, tbl[i].rv);
      chk1($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].bsy);
      if (tbl[i].rv) begin
        chk1($sformatf("tbl%0d_rsp_id", i), bus.rsp_id, tbl[i].rid);
        chk32($sformatf("tbl%0d_rsp_data", i), bus.rsp_data, tbl[i].rd);
      end
      step();
    end

    // ---------------- fairness: both hold READs, last winner was A ----------------
    set_a(1'b1, OPR, 2'd0, 32'h0);
    set_b(1'b1, OPR, 2'd1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("rr%0d_a_gnt", i), bus.a_gnt, (i % 2) == 1);
      chk1($sformatf("rr%0d_b_gnt", i), bus.b_gnt, (i % 2) == 0);
      if (i > 0) begin
        chk1($sformatf("rr%0d_rsp_id", i), bus.rsp_id, (i % 2) == 1);
        chk32($sformatf("rr%0d_rsp_data", i), bus.rsp_data, ((i % 2) == 1) ? 32'h20 : 32'h10);
      end
      step();
    end
    set_a(1'b0, OPW, 2'd0, 32'h0);
    set_b(1'b0, OPW, 2'd0, 32'h0);
    step();

    // ---------------- sweep clear with B waiting ----------------
    for (int i = 0; i < 4; i++) do_write_a(2'(i), 32'hFFFF_FFFF);
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk1("clr_pulse_busy", bus.busy, 1'b0);
    step();
    bus.clr_req = 1'b0;
    set_b(1'b1, OPR, 2'd3, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1($sformatf("sweep%0d_b_gnt", k), bus.b_gnt, 1'b0);
      chk1($sformatf("sweep%0d_busy", k), bus.busy, 1'b1);
      chk1($sformatf("sweep%0d_rsp_valid", k), bus.rsp_valid, 1'b0);
      step();
    end
    @(negedge clk);
    chk1("sweep_done_b_gnt", bus.b_gnt, 1'b1);
    chk1("sweep_done_busy", bus.busy, 1'b0);
    step();
    set_b(1'b0, OPW, 2'd0, 32'h0);
    @(negedge clk);
    chk32("sweep_b_read", bus.rsp_data, 32'h0);
    step();
    for (int i = 0; i < 3; i++) do_read_a(2'(i), 32'h0);

    // ---------------- clear during RMW, second clear during sweep ----------------
    do_write_a(2'd1, 32'h100);
    set_a(1'b1, OPH, 2'd1, 32'h0);
    @(negedge clk);
    chk1("rmwclr_gnt", bus.a_gnt, 1'b1);
    step();
    set_a(1'b1, OPR, 2'd1, 32'h0);
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk1("rmwclr_rmw_gnt", bus.a_gnt, 1'b0);
    chk1("rmwclr_rmw_busy", bus.busy, 1'b1);
    step();
    bus.clr_req = 1'b0;
    @(negedge clk);
    chk1("rmwclr_rsp_valid", bus.rsp_valid, 1'b1);
    chk32("rmwclr_rsp_data", bus.rsp_data, 32'h80);
    chk1("rmwclr_pend_gnt", bus.a_gnt, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      bus.clr_req = (k == 1);
      @(negedge clk);
      chk1($sformatf("rmwsweep%0d_gnt", k), bus.a_gnt, 1'b0);
      chk1($sformatf("rmwsweep%0d_busy", k), bus.busy, 1'b1);
      step();
    end
    bus.clr_req = 1'b0;
    @(negedge clk);
    chk1("nosweep2_gnt", bus.a_gnt, 1'b1);
    chk1("nosweep2_busy", bus.busy, 1'b0);
    step();
    set_a(1'b0, OPW, 2'd0, 32'h0);
    @(negedge clk);
    chk1("nosweep2_rsp_valid", bus.rsp_valid, 1'b1);
    chk32("nosweep2_rsp_data", bus.rsp_data, 32'h0);
    step();
    @(negedge clk);
    chk1("nosweep2_idle_busy", bus.busy, 1'b0);
    step();

    // ---------------- reset in the RMW cycle ----------------
    do_write_a(2'd0, 32'h55);
    set_a(1'b1, OPH, 2'd0, 32'h0);
    @(negedge clk);
    chk1("rstrmw_gnt", bus.a_gnt, 1'b1);
    step();
    set_a(1'b0, OPW, 2'd0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk1("rstrmw_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rstrmw_rsp_id", bus.rsp_id, 1'b0);
    chk32("rstrmw_rsp_data", bus.rsp_data, 32'h0);
    chk1("rstrmw_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk1("rstrmw_rsp_valid2", bus.rsp_valid, 1'b0);
    reset = 1'b0;
    step();
    do_read_a(2'd0, 32'h0);
    do_read_a(2'd1, 32'h0);

    // ---------------- random traffic against the model ----------------
    do_reset();
    for (int i = 0; i < 4; i++) mm[i] = 32'h0;
    m_last = 1'b1; m_pend = 1'b0; m_free = 0; m_win = -100; c = 0;
    ap = 1'b0; bp = 1'b0;
    aop_v = OPW; bop_v = OPW; aad_v = 2'd0; bad_v = 2'd0; awd_v = 32'h0; bwd_v = 32'h0;
    for (int it = 0; it < 800; it++) begin
      if (!ap && ($urandom_range(0, 1) == 0)) begin
        ap = 1'b1; aop_v = 2'($urandom_range(0, 3)); aad_v = 2'($urandom_range(0, 3));
        awd_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      if (!bp && ($urandom_range(0, 1) == 0)) begin
        bp = 1'b1; bop_v = 2'($urandom_range(0, 3)); bad_v = 2'($urandom_range(0, 3));
        bwd_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      clr = ($urandom_range(0, 29) == 0);
      set_a(ap, aop_v, aad_v, awd_v);
      set_b(bp, bop_v, bad_v, bwd_v);
      bus.clr_req = clr;

      ebusy = (c < m_free) || m_pend;
      ea = 1'b0; eb = 1'b0;
      if (c >= m_free) begin
        if (m_pend) begin
          m_pend = 1'b0;
          for (int k = 0; k < 4; k++) mm[k] = 32'h0;
          m_free = c + 5;
          m_win  = c;
        end else if (ap || bp) begin
          wid  = (ap && bp) ? !m_last : bp;
          m_last = wid;
          ea = !wid; eb = wid;
          op_v = wid ? bop_v : aop_v;
          ad_v = wid ? bad_v : aad_v;
          wd_v = wid ? bwd_v : awd_v;
          case (op_v)
            OPW:     begin mm[ad_v] = wd_v;          rd_v = wd_v;     m_free = c + 1; end
            OPR:     begin                           rd_v = mm[ad_v]; m_free = c + 1; end
            OPH:     begin mm[ad_v] = mm[ad_v] / 2;  rd_v = mm[ad_v]; m_free = c + 2; end
            default: begin mm[ad_v] = mm[ad_v] / 4;  rd_v = mm[ad_v]; m_free = c + 2; end
          endcase
          r.due = m_free; r.id = wid; r.d = rd_v;
          q.push_back(r);
        end
      end
      if (clr && !((c >= m_win) && (c <= m_win + 4))) m_pend = 1'b1;

      @(negedge clk);
      chk1("rnd_a_gnt", bus.a_gnt, ea);
      chk1("rnd_b_gnt", bus.b_gnt, eb);
      chk1("rnd_busy", bus.busy, ebusy);
      if ((q.size() > 0) && (q[0].due == c)) begin
        r = q.pop_front();
        chk1("rnd_rsp_valid", bus.rsp_valid, 1'b1);
        chk1("rnd_rsp_id", bus.rsp_id, r.id);
        chk32("rnd_rsp_data", bus.rsp_data, r.d);
      end else begin
        chk1("rnd_rsp_valid", bus.rsp_valid, 1'b0);
      end
      if (ea) ap = 1'b0;
      if (eb) bp = 1'b0;
      step();
      c++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
